// File: rtl/slv_wr_resp.sv
// Slave write-response path: takes write bursts from the crossbar, queues
// beats in a 2-entry FIFO, streams them to memory, and reports completion.
// Optional build macro WR_BURST_CHK_EN adds burst length and address
// continuity checking; without it only aborted bursts are flagged as errors.
module slv_wr_resp #(
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int SW      = 4,
  parameter int MAXBEAT = 16
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iSlvWrReq,
  input  logic          iSlvWrValid,
  input  logic [AW-1:0] iSlvWrAddr,
  input  logic [SW-1:0] iSlvWrSel,
  input  logic [DW-1:0] iSlvWrData,
  input  logic          iSlvWrLast,
  output logic          oSlvWrReady,
  output logic          oMemWrEn,
  output logic [AW-1:0] oMemWrAddr,
  output logic [SW-1:0] oMemWrBe,
  output logic [DW-1:0] oMemWrData,
  input  logic          iMemWrRdy,
  output logic          oWrDone,
  output logic          oWrErr,
  output logic [4:0]    oWrBeatCnt
);

  localparam int EW = AW + SW + DW;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    fifo_cnt;
  logic [EW-1:0] head;
  logic [EW-1:0] tail;
  logic [EW-1:0] beat_in;
  logic [4:0]    beat_cnt;
  logic          err_flag;
  logic          fifo_full;
  logic          fifo_empty;
  logic          beat_acc;
  logic          pop;
  logic          push;
  logic          chk_err;
  logic          abort;
  logic          burst_start;

  // Handshake and FIFO status decode shared by the FSM and datapath
  always_comb begin
    fifo_full   = (fifo_cnt == 2'd2);
    fifo_empty  = (fifo_cnt == 2'd0);
    oSlvWrReady = (state == BURST) && !fifo_full;
    beat_acc    = iSlvWrValid && oSlvWrReady;
    pop         = !fifo_empty && iMemWrRdy;
    beat_in     = {iSlvWrAddr, iSlvWrSel, iSlvWrData};
    burst_start = (state == IDLE) && iSlvWrReq;
    abort       = (state == BURST) && !iSlvWrReq && !(beat_acc && iSlvWrLast);
  end

`ifdef WR_BURST_CHK_EN
  logic [AW-1:0] prev_addr;
  logic          over_len;
  logic          addr_jump;

  // Flag over-length bursts and address discontinuities; over-length beats are dropped
  always_comb begin
    over_len  = (int'(beat_cnt) >= MAXBEAT);
    addr_jump = (beat_cnt != 5'd0) && (iSlvWrAddr != prev_addr + AW'(1));
    chk_err   = beat_acc && (over_len || addr_jump);
    push      = beat_acc && !over_len;
  end

  // Remember the previous accepted address for the continuity check
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)       prev_addr <= '0;
    else if (beat_acc) prev_addr <= iSlvWrAddr;
  end
`else
  // Without checking every accepted beat goes to memory
  always_comb begin
    chk_err = 1'b0;
    push    = beat_acc;
  end
`endif

  // State register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: a burst ends on its last beat or when the request drops
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (iSlvWrReq) state_nxt = BURST;
      BURST: if ((beat_acc && iSlvWrLast) || !iSlvWrReq) state_nxt = DRAIN;
      DRAIN: if (fifo_empty) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating beat counter, cleared when a new burst starts
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)                            beat_cnt <= 5'd0;
    else if (burst_start)                   beat_cnt <= 5'd0;
    else if (beat_acc && beat_cnt != 5'd31) beat_cnt <= beat_cnt + 5'd1;
  end

  // Sticky error flag for the current burst, reported in the DONE cycle
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)               err_flag <= 1'b0;
    else if (burst_start)      err_flag <= 1'b0;
    else if (abort || chk_err) err_flag <= 1'b1;
  end

  // Two-entry shift FIFO; the head register drives the memory port directly
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      fifo_cnt <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (fifo_empty) head <= beat_in;
          else            tail <= beat_in;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head     <= tail;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: head <= beat_in;
        default: ;
      endcase
    end
  end

  // Output drive
  always_comb begin
    oMemWrEn                             = !fifo_empty;
    {oMemWrAddr, oMemWrBe, oMemWrData}   = head;
    oWrDone                              = (state == DONE);
    oWrErr                               = (state == DONE) && err_flag;
    oWrBeatCnt                           = beat_cnt;
  end

endmodule

// File: tb/tb_slv_wr_resp.sv
// Testbench for slv_wr_resp: scenario tasks with a queue-based reference
// model of expected memory writes, done/error pulses and beat counts.
// Expectations follow WR_BURST_CHK_EN when the build defines it.
module tb_slv_wr_resp;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MAXBEAT = 16;
`ifdef WR_BURST_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [SW-1:0] s;
    logic [DW-1:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          valid = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [SW-1:0] sel = '0;
  logic [DW-1:0] data = '0;
  logic          last = 1'b0;
  logic          ready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_data;
  logic          mem_rdy = 1'b1;
  logic          done;
  logic          err;
  logic [4:0]    beat_cnt;

  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;
  int    rdy_mode = 0;
  beat_t exp_q[$];
  int    wr_cyc_q[$];

  slv_wr_resp #(.AW(AW), .DW(DW), .SW(SW), .MAXBEAT(MAXBEAT)) dut (
    .iClk(clk), .iRst_n(rst_n), .iSlvWrReq(req), .iSlvWrValid(valid),
    .iSlvWrAddr(addr), .iSlvWrSel(sel), .iSlvWrData(data), .iSlvWrLast(last),
    .oSlvWrReady(ready), .oMemWrEn(mem_en), .oMemWrAddr(mem_addr),
    .oMemWrBe(mem_be), .oMemWrData(mem_data), .iMemWrRdy(mem_rdy),
    .oWrDone(done), .oWrErr(err), .oWrBeatCnt(beat_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory-side ready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: mem_rdy = 1'b1;
        1: mem_rdy = 1'($urandom_range(0, 1));
        default: mem_rdy = 1'b0;
      endcase
    end
  end

  // Memory-side scoreboard: each consumed write must match the oldest expected beat
  always @(negedge clk) begin
    if (rst_n && mem_en && mem_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_be, mem_data} !== e)
          $display("FAIL mem_write: got %0h/%0h/%0h required %0h/%0h/%0h",
                   mem_addr, mem_be, mem_data, e.a, e.s, e.d);
        else passed++;
      end
      wr_cyc_q.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic begin_burst();
    @(posedge clk);
    #1;
    req = 1'b1;
  endtask

  task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic is_last, input bit expect_write);
    beat_t b;
    bit got;
    got = 1'b0;
    b.a = a;
    b.s = SW'($urandom);
    b.d = d;
    valid = 1'b1;
    addr = b.a;
    sel = b.s;
    data = b.d;
    last = is_last;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        if (expect_write) exp_q.push_back(b);
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    last = 1'b0;
    checks++;
    if (!got) $display("FAIL beat_accept: got no Ready in 64 cycles, required acceptance");
    else passed++;
  endtask

  task automatic finish_burst(input string name, input bit drop_req,
                              input int exp_cnt, input bit exp_err);
    bit found;
    found = 1'b0;
    if (drop_req) req = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    checks++;
    if (!found) begin
      $display("FAIL %s_done: got no oWrDone in 200 cycles, required pulse", name);
    end else begin
      passed++;
      checks++;
      if (err !== exp_err) $display("FAIL %s_err: got %0b required %0b", name, err, exp_err);
      else passed++;
      checks++;
      if (beat_cnt !== 5'(exp_cnt)) $display("FAIL %s_cnt: got %0d required %0d", name, beat_cnt, exp_cnt);
      else passed++;
      checks++;
      if (exp_q.size() != 0) $display("FAIL %s_pending: got %0d writes outstanding required 0", name, exp_q.size());
      else passed++;
      @(negedge clk);
      checks++;
      if ({done, err} !== 2'b00) $display("FAIL %s_pulse: got done/err %0b%0b one cycle later required 00", name, done, err);
      else passed++;
      checks++;
      if (beat_cnt !== 5'(exp_cnt)) $display("FAIL %s_cnt_hold: got %0d required %0d", name, beat_cnt, exp_cnt);
      else passed++;
    end
    @(posedge clk);
    #1;
  endtask

  // Reference model: which beats are written, final count and error from burst shape
  task automatic run_burst(input string name, input int n, input logic [AW-1:0] base,
                           input logic [DW-1:0] dbase, input int jump_at,
                           input int abort_at, input bit keep_req);
    int k;
    bit aborted;
    bit exp_err;
    int exp_cnt;
    logic [AW-1:0] a;
    k = (abort_at > 0 && abort_at < n) ? abort_at : n;
    aborted = (k < n);
    begin_burst();
    for (int i = 0; i < k; i++) begin
      a = base + AW'(i) + ((jump_at > 0 && i >= jump_at) ? AW'(15) : AW'(0));
      send_beat(a, dbase + DW'(i), !aborted && (i == n - 1), !CHK || (i < MAXBEAT));
    end
    exp_cnt = (k > 31) ? 31 : k;
    exp_err = aborted || (CHK && ((k > MAXBEAT) || (jump_at > 0 && jump_at < k)));
    finish_burst(name, !keep_req || aborted, exp_cnt, exp_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, mem_en, done, err} !== 4'b0000)
      $display("FAIL reset_flags: got %0b%0b%0b%0b required 0000", ready, mem_en, done, err);
    else passed++;
    checks++;
    if ({mem_addr, mem_be, mem_data, beat_cnt} !== '0)
      $display("FAIL reset_data: got %0h/%0h/%0h/%0d required 0", mem_addr, mem_be, mem_data, beat_cnt);
    else passed++;
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready, mem_en, done} !== 3'b000)
      $display("FAIL idle_after_reset: got %0b%0b%0b required 000", ready, mem_en, done);
    else passed++;
  endtask

  task automatic test_basic();
    wr_cyc_q.delete();
    run_burst("basic", 4, 12'h010, 32'hA0, 0, 0, 1'b0);
    checks++;
    if (wr_cyc_q.size() != 4 || (wr_cyc_q[3] - wr_cyc_q[0]) != 3)
      $display("FAIL basic_consecutive: got %0d writes spread %0d cycles required 4 over 3",
               wr_cyc_q.size(), wr_cyc_q.size() > 0 ? wr_cyc_q[wr_cyc_q.size()-1] - wr_cyc_q[0] : -1);
    else passed++;
  endtask

  task automatic test_backpressure();
    int accepted;
    beat_t b;
    accepted = 0;
    rdy_mode = 2;
    begin_burst();
    for (int c = 0; c < 8; c++) begin
      if (accepted < 4) begin
        b.a = 12'h010 + AW'(accepted);
        b.s = 4'hF;
        b.d = 32'hA0 + DW'(accepted);
        valid = 1'b1; addr = b.a; sel = b.s; data = b.d; last = (accepted == 3);
      end else valid = 1'b0;
      @(negedge clk);
      if (valid && ready) begin
        exp_q.push_back(b);
        accepted++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checks++;
    if (accepted != 2) $display("FAIL bp_accepted: got %0d beats required 2", accepted);
    else passed++;
    checks++;
    if (ready !== 1'b0) $display("FAIL bp_ready: got %0b required 0", ready);
    else passed++;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    for (int i = accepted; i < 4; i++)
      send_beat(12'h010 + AW'(i), 32'hA0 + DW'(i), i == 3, 1'b1);
    finish_burst("backpressure", 1'b1, 4, 1'b0);
  endtask

  task automatic test_abort();
    run_burst("abort", 4, 12'h030, 32'hB0, 0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_a", 3, 12'h100, 32'h11, 0, 0, 1'b1);
    run_burst("b2b_b", 5, 12'h200, 32'h22, 0, 0, 1'b1);
    run_burst("b2b_c", 2, 12'h300, 32'h33, 0, 0, 1'b0);
  endtask

  task automatic test_length_and_jump();
    run_burst("len19", 19, 12'h040, 32'hC0, 0, 0, 1'b0);
    run_burst("len33", 33, 12'hFF0, 32'hD0, 0, 0, 1'b0);
    run_burst("jump", 4, 12'h010, 32'hE0, 1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    rdy_mode = 2;
    begin_burst();
    send_beat(12'h050, 32'h1, 1'b0, 1'b1);
    send_beat(12'h051, 32'h2, 1'b0, 1'b1);
    valid = 1'b1; addr = 12'h052; data = 32'h3;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, mem_en, done, err} !== 4'b0000)
      $display("FAIL midrst_flags: got %0b%0b%0b%0b required 0000", ready, mem_en, done, err);
    else passed++;
    checks++;
    if ({mem_addr, mem_be, mem_data, beat_cnt} !== '0)
      $display("FAIL midrst_data: got %0h/%0h/%0h/%0d required 0", mem_addr, mem_be, mem_data, beat_cnt);
    else passed++;
    exp_q.delete();
    valid = 1'b0;
    req = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run_burst("after_rst", 4, 12'h010, 32'hA0, 0, 0, 1'b0);
  endtask

  task automatic test_random();
    rdy_mode = 1;
    for (int it = 0; it < 12; it++) begin
      int n;
      int jmp;
      int abt;
      n = $urandom_range(1, 10);
      jmp = ($urandom_range(0, 2) == 0 && n > 1) ? $urandom_range(1, n - 1) : 0;
      abt = ($urandom_range(0, 3) == 0 && n > 1) ? $urandom_range(1, n - 1) : 0;
      run_burst("rand", n, AW'($urandom), DW'($urandom), jmp, abt, 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_length_and_jump();
    test_reset_mid_burst();
    test_random();
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/slv_wr_resp.md
SLV_WR_RESP -- requirements
Module: slv_wr_resp

Interface
REQ-001 Parameters (name, default, meaning): AW, 12, address width; DW, 32, data width; SW, 4, byte-select width; MAXBEAT, 16, max beats per burst.
REQ-002 iClk  input  1  clock; all logic on rising edge.
REQ-003 iRst_n  input  1  reset, asynchronous, active-low.
REQ-004 iSlvWrReq  input  1  burst request from crossbar write path.
REQ-005 iSlvWrValid  input  1  beat valid.
REQ-006 iSlvWrAddr / iSlvWrSel / iSlvWrData  input  AW / SW / DW  beat address, byte select, data.
REQ-007 iSlvWrLast  input  1  final beat of burst.
REQ-008 oSlvWrReady  output  1  beat accepted when Valid && Ready.
REQ-009 oMemWrEn  output  1  memory write strobe.
REQ-010 oMemWrAddr / oMemWrBe / oMemWrData  output  AW / SW / DW  memory write address, byte enable, data.
REQ-011 iMemWrRdy  input  1  memory consumes beat when oMemWrEn && iMemWrRdy.
REQ-012 oWrDone  output  1  one-cycle burst-complete pulse.
REQ-013 oWrErr  output  1  one-cycle error pulse, only coincident with oWrDone.
REQ-014 oWrBeatCnt  output  5  accepted beats in current/last burst.

Function
REQ-015 FSM states IDLE, BURST, DRAIN, DONE.
- IDLE->BURST when iSlvWrReq=1.
- BURST->DRAIN on accepted beat with iSlvWrLast=1, or on iSlvWrReq=0 before Last (abort).
- DRAIN->DONE when FIFO empty.
- DONE->IDLE unconditionally after one cycle.
REQ-016 Internal 2-entry FIFO holds {addr, sel, data}; oSlvWrReady = (state==BURST) && FIFO not full; Ready does not depend on iMemWrRdy.
REQ-017 oMemWrEn = FIFO not empty; oMem* driven from FIFO head registers; beat accepted at cycle N appears on oMem* at N+1 at the earliest.
REQ-018 Simultaneous push and pop leaves occupancy unchanged; with iMemWrRdy held 1, one beat per cycle is sustained.
REQ-019 Beats arriving in IDLE, DRAIN, DONE are not accepted (Ready=0).
REQ-020 oWrBeatCnt clears on IDLE->BURST, increments per accepted beat, saturates at 31, holds through DONE and IDLE.
REQ-021 oWrDone=1 for exactly the DONE cycle; oWrErr=1 in that cycle if the burst aborted or a check (REQ-025) failed.
REQ-022 iSlvWrReq=1 in DONE does not extend DONE; new burst starts from IDLE on the following cycle.

Reset
REQ-023 On iRst_n=0, state=IDLE, FIFO empty, error flag cleared; all outputs 0 (oMemWrAddr/Be/Data 0, oWrBeatCnt 0).
REQ-024 Reset asserted mid-burst discards queued beats immediately; no memory write issues until a new burst.

Configuration
REQ-025 Macro WR_BURST_CHK_EN defined: error is flagged if a beat is accepted after MAXBEAT beats without Last, or if a beat address differs from previous beat address+1 (mod 2^AW); beats beyond MAXBEAT are accepted but not pushed to FIFO (no memory write). Error recorded at offending beat, reported per REQ-021.
REQ-026 Macro WR_BURST_CHK_EN not defined: no length/address check; all accepted beats are written; oWrErr reports abort only.

Verification
REQ-027 Req=1, 4 beats addr 0x010..0x013 data 0xA0..0xA3, Last on beat 4, iMemWrRdy=1 -> 4 consecutive oMemWrEn cycles, same addr/data, oWrBeatCnt=4, oWrDone pulse, oWrErr=0.
REQ-028 Same burst, iMemWrRdy=0 for 5 cycles -> Ready drops after 2 accepted beats, no data lost, writes in order once Rdy=1.
REQ-029 Req drops after 2 of 4 beats -> 2 memory writes, oWrBeatCnt=2, oWrDone and oWrErr pulse together.
REQ-030 WR_BURST_CHK_EN: 18 beats without Last then Last on beat 19 -> 16 memory writes, oWrErr=1 at done; addr jump 0x010->0x020 -> oWrErr=1, all beats written.
REQ-031 iRst_n low during beat 3 of 8 -> all outputs 0 next cycle, FIFO empty, next burst behaves per REQ-027.
